// File: rtl/n64_button_event_fifo.sv
// n64_button_event_fifo
// Debounces the 32-bit N64 controller button word across consecutive polls,
// detects committed changes on masked bits and queues each change in an
// event FIFO drained by the APB side. An interrupt flags pending events or a
// dropped event so firmware need not poll the controller register.
//
// Ports:
//   PCLK          system clock
//   PRESERN       asynchronous active-low reset
//   button_data   latest controller word from the serial interface
//   button_valid  one-cycle strobe, button_data is a freshly completed poll
//   change_mask   1 = bit participates in debounce and change detection
//   fifo_pop      one-cycle request to remove the head entry
//   irq_enable    gates the irq output
//   overflow_clr  clears the sticky overflow flag
//   fifo_rd_data  head entry (show-ahead), 0 when empty
//   fifo_empty    FIFO holds no entries
//   fifo_full     FIFO holds DEPTH entries
//   fifo_count    current occupancy
//   overflow      sticky flag, at least one event was dropped
//   irq           registered interrupt request
module n64_button_event_fifo #(
  parameter int DEPTH          = 8,
  parameter int ADDR_W         = 3,
  parameter int STABLE_SAMPLES = 2,
  parameter int IRQ_THRESHOLD  = 1
) (
  input  logic              PCLK,
  input  logic              PRESERN,
  input  logic [31:0]       button_data,
  input  logic              button_valid,
  input  logic [31:0]       change_mask,
  input  logic              fifo_pop,
  input  logic              irq_enable,
  input  logic              overflow_clr,
  output logic [31:0]       fifo_rd_data,
  output logic              fifo_empty,
  output logic              fifo_full,
  output logic [ADDR_W:0]   fifo_count,
  output logic              overflow,
  output logic              irq
);

  localparam logic [3:0]      STABLE_C = 4'(STABLE_SAMPLES);
  localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] IRQ_TH_C = (ADDR_W + 1)'(IRQ_THRESHOLD);

  // Debounce state
  logic [31:0]       candidate_q, candidate_d;
  logic [31:0]       committed_q, committed_d;
  logic [3:0]        stable_cnt_q, stable_cnt_d;

  // FIFO state
  logic [31:0]       mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [31:0]       rd_data_q, rd_data_d;
  logic              empty_q, empty_d;
  logic              full_q, full_d;
  logic              overflow_q, overflow_d;
  logic              irq_q, irq_d;

  // Control strobes
  logic              push_s;
  logic              push_ok_s;
  logic              pop_ok_s;
  logic              drop_s;

  // Debounce and commit: a push is issued when the masked candidate has been
  // stable long enough and differs from the last committed word.
  always_comb begin
    candidate_d  = candidate_q;
    committed_d  = committed_q;
    stable_cnt_d = stable_cnt_q;
    push_s       = 1'b0;
    if (button_valid) begin
      if ((button_data & change_mask) == (candidate_q & change_mask)) begin
        if (stable_cnt_q >= STABLE_C) begin
          stable_cnt_d = STABLE_C;
        end else begin
          stable_cnt_d = stable_cnt_q + 4'd1;
        end
      end else begin
        candidate_d  = button_data;
        stable_cnt_d = 4'd1;
      end
      if ((stable_cnt_d == STABLE_C) &&
          ((candidate_d & change_mask) != (committed_q & change_mask))) begin
        // committed follows even when the push is dropped, so tracking stays
        // aligned with the controller after an overflow
        committed_d = candidate_d;
        push_s      = 1'b1;
      end else begin
        push_s      = 1'b0;
      end
    end else begin
      push_s = 1'b0;
    end
  end

  // FIFO pointer, occupancy, flag and registered-output next-state logic
  always_comb begin
    pop_ok_s   = fifo_pop && (count_q != '0);
    // a pop in the same cycle frees the slot, so a full FIFO still accepts
    push_ok_s  = push_s && ((count_q != DEPTH_C) || pop_ok_s);
    drop_s     = push_s && !push_ok_s;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rd_data_d  = 32'h0000_0000;
    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + {{ADDR_W{1'b0}}, 1'b1};
      2'b01:   count_d = count_q - {{ADDR_W{1'b0}}, 1'b1};
      default: count_d = count_q;
    endcase
    // next head: bypass the word being written if it lands at the new head
    if (count_d == '0) begin
      rd_data_d = 32'h0000_0000;
    end else if (push_ok_s && (wr_ptr_q == rd_ptr_d)) begin
      rd_data_d = candidate_d;
    end else begin
      rd_data_d = mem_q[rd_ptr_d];
    end
    empty_d = (count_d == '0);
    full_d  = (count_d == DEPTH_C);
    if (drop_s) begin
      overflow_d = 1'b1;
    end else if (overflow_clr) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
    irq_d = irq_enable & ((count_d >= IRQ_TH_C) | overflow_d);
  end

  // Event storage; contents only matter below the occupancy, so no reset
  always_ff @(posedge PCLK) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= candidate_d;
    end
  end

  // State and output registers
  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      candidate_q  <= 32'h0000_0000;
      committed_q  <= 32'h0000_0000;
      stable_cnt_q <= 4'd0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      rd_data_q    <= 32'h0000_0000;
      empty_q      <= 1'b1;
      full_q       <= 1'b0;
      overflow_q   <= 1'b0;
      irq_q        <= 1'b0;
    end else begin
      candidate_q  <= candidate_d;
      committed_q  <= committed_d;
      stable_cnt_q <= stable_cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      rd_data_q    <= rd_data_d;
      empty_q      <= empty_d;
      full_q       <= full_d;
      overflow_q   <= overflow_d;
      irq_q        <= irq_d;
    end
  end

  assign fifo_rd_data = rd_data_q;
  assign fifo_empty   = empty_q;
  assign fifo_full    = full_q;
  assign fifo_count   = count_q;
  assign overflow     = overflow_q;
  assign irq          = irq_q;

endmodule

// File: tb/tb_n64_button_event_fifo.sv
// Directed bench for n64_button_event_fifo with hand-computed expectations.
module tb_n64_button_event_fifo;

  logic        PCLK;
  logic        PRESERN;
  logic [31:0] button_data;
  logic        button_valid;
  logic [31:0] change_mask;
  logic        fifo_pop;
  logic        irq_enable;
  logic        overflow_clr;
  logic [31:0] fifo_rd_data;
  logic        fifo_empty;
  logic        fifo_full;
  logic [3:0]  fifo_count;
  logic        overflow;
  logic        irq;

  int n_checks;
  int n_fail;

  n64_button_event_fifo dut (
    .PCLK         (PCLK),
    .PRESERN      (PRESERN),
    .button_data  (button_data),
    .button_valid (button_valid),
    .change_mask  (change_mask),
    .fifo_pop     (fifo_pop),
    .irq_enable   (irq_enable),
    .overflow_clr (overflow_clr),
    .fifo_rd_data (fifo_rd_data),
    .fifo_empty   (fifo_empty),
    .fifo_full    (fifo_full),
    .fifo_count   (fifo_count),
    .overflow     (overflow),
    .irq          (irq)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One cycle of stimulus, applied at a falling edge and released at the next
  task automatic cycle(input logic valid, input logic [31:0] data,
                       input logic pop, input logic clr);
    @(negedge PCLK);
    button_valid = valid;
    button_data  = data;
    fifo_pop     = pop;
    overflow_clr = clr;
    @(negedge PCLK);
    button_valid = 1'b0;
    fifo_pop     = 1'b0;
    overflow_clr = 1'b0;
  endtask

  task automatic poll(input logic [31:0] data);
    cycle(1'b1, data, 1'b0, 1'b0);
  endtask

  task automatic pop_one();
    cycle(1'b0, 32'h0000_0000, 1'b1, 1'b0);
  endtask

  function automatic logic [31:0] ev(input int i);
    logic [31:0] v;
    v = 32'h0100_0000 * (i + 1);
    return v | 32'h0000_00A0 | 32'(i);
  endfunction

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_count"}, {28'h0, fifo_count}, 32'd0);
    check_eq({tag, "_empty"}, {31'h0, fifo_empty}, 32'd1);
    check_eq({tag, "_full"},  {31'h0, fifo_full},  32'd0);
    check_eq({tag, "_rd"},    fifo_rd_data,        32'h0000_0000);
    check_eq({tag, "_ovf"},   {31'h0, overflow},   32'd0);
    check_eq({tag, "_irq"},   {31'h0, irq},        32'd0);
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    PRESERN      = 1'b0;
    button_data  = 32'h0000_0000;
    button_valid = 1'b0;
    change_mask  = 32'hFFFF_0000;
    fifo_pop     = 1'b0;
    irq_enable   = 1'b1;
    overflow_clr = 1'b0;
    repeat (2) @(negedge PCLK);
    check_reset_state("rst");
    PRESERN = 1'b1;
    @(negedge PCLK);

    // First stable change commits after two polls
    poll(32'h0010_0000);
    check_eq("first_poll_count", {28'h0, fifo_count}, 32'd0);
    poll(32'h0010_0000);
    check_eq("commit_count", {28'h0, fifo_count}, 32'd1);
    check_eq("commit_rd", fifo_rd_data, 32'h0010_0000);
    check_eq("commit_empty", {31'h0, fifo_empty}, 32'd0);
    check_eq("commit_irq", {31'h0, irq}, 32'd1);

    // Glitch value is replaced before it becomes stable
    poll(32'h0020_0000);
    poll(32'h0040_0000);
    check_eq("glitch_count", {28'h0, fifo_count}, 32'd1);
    poll(32'h0040_0000);
    check_eq("deglitch_count", {28'h0, fifo_count}, 32'd2);
    check_eq("deglitch_head", fifo_rd_data, 32'h0010_0000);

    // Unmasked bits alone never push
    poll(32'h0040_ABCD);
    poll(32'h0040_1234);
    poll(32'h0040_1234);
    check_eq("unmasked_count", {28'h0, fifo_count}, 32'd2);

    // Drain, then pop on empty
    pop_one();
    check_eq("pop1_head", fifo_rd_data, 32'h0040_0000);
    check_eq("pop1_count", {28'h0, fifo_count}, 32'd1);
    pop_one();
    check_eq("pop2_count", {28'h0, fifo_count}, 32'd0);
    check_eq("pop2_empty", {31'h0, fifo_empty}, 32'd1);
    check_eq("pop2_rd", fifo_rd_data, 32'h0000_0000);
    check_eq("pop2_irq", {31'h0, irq}, 32'd0);
    pop_one();
    check_eq("pop_empty_count", {28'h0, fifo_count}, 32'd0);
    check_eq("pop_empty_flag", {31'h0, fifo_empty}, 32'd1);

    // Nine distinct stable changes into an eight-entry FIFO
    for (int i = 0; i < 9; i++) begin
      poll(ev(i));
      poll(ev(i));
      if (i == 7) begin
        check_eq("fill8_full", {31'h0, fifo_full}, 32'd1);
        check_eq("fill8_ovf", {31'h0, overflow}, 32'd0);
      end
    end
    check_eq("ovf_count", {28'h0, fifo_count}, 32'd8);
    check_eq("ovf_full", {31'h0, fifo_full}, 32'd1);
    check_eq("ovf_flag", {31'h0, overflow}, 32'd1);
    check_eq("ovf_irq", {31'h0, irq}, 32'd1);
    check_eq("ovf_head", fifo_rd_data, ev(0));

    // Push and pop together while full
    poll(32'h0A00_0000);
    cycle(1'b1, 32'h0A00_0000, 1'b1, 1'b0);
    check_eq("pp_count", {28'h0, fifo_count}, 32'd8);
    check_eq("pp_head", fifo_rd_data, ev(1));

    // Clear coinciding with a drop leaves overflow set
    poll(32'h0B00_0000);
    cycle(1'b1, 32'h0B00_0000, 1'b0, 1'b1);
    check_eq("clr_drop_ovf", {31'h0, overflow}, 32'd1);
    check_eq("clr_drop_count", {28'h0, fifo_count}, 32'd8);
    cycle(1'b0, 32'h0000_0000, 1'b0, 1'b1);
    check_eq("clr_ovf", {31'h0, overflow}, 32'd0);
    check_eq("clr_irq", {31'h0, irq}, 32'd1);

    // Drain in order: ev1..ev7 then the push-and-pop entry
    for (int i = 1; i < 8; i++) begin
      check_eq($sformatf("drain_%0d", i), fifo_rd_data, ev(i));
      pop_one();
    end
    check_eq("drain_tail", fifo_rd_data, 32'h0A00_0000);
    pop_one();
    check_eq("drain_empty", {31'h0, fifo_empty}, 32'd1);
    check_eq("drain_irq", {31'h0, irq}, 32'd0);

    // irq gating by irq_enable
    irq_enable = 1'b0;
    poll(32'h0D00_0000);
    poll(32'h0D00_0000);
    check_eq("gate_count", {28'h0, fifo_count}, 32'd1);
    check_eq("gate_irq_off", {31'h0, irq}, 32'd0);
    irq_enable = 1'b1;
    @(negedge PCLK);
    check_eq("gate_irq_on", {31'h0, irq}, 32'd1);

    // Asynchronous reset mid-stream
    poll(32'h0C00_0000);
    poll(32'h0C00_0000);
    check_eq("pre_rst_count", {28'h0, fifo_count}, 32'd2);
    #2;
    PRESERN = 1'b0;
    #1;
    check_reset_state("async_rst");
    @(negedge PCLK);
    PRESERN = 1'b1;
    @(negedge PCLK);
    check_eq("post_rst_count", {28'h0, fifo_count}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
